// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - RV32I format, opcode and error-code constants shared by the encoder slice
package rv_pkg;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_ISH = 3'd2;
    localparam logic [2:0] FMT_S   = 3'd3;
    localparam logic [2:0] FMT_B   = 3'd4;
    localparam logic [2:0] FMT_U   = 3'd5;
    localparam logic [2:0] FMT_J   = 3'd6;
    localparam logic [2:0] FMT_RSV = 3'd7;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] LOAD   = 7'b0000011;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_RANGE    = 3'd1;
    localparam logic [2:0] ERR_MISALIGN = 3'd2;
    localparam logic [2:0] ERR_U_LOW    = 3'd3;
    localparam logic [2:0] ERR_BAD_FMT  = 3'd4;

    // True when v is representable as an nbits-wide two's complement value.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned nbits);
        logic [31:0] hi;
        hi = 32'($signed(v) >>> (nbits - 1));
        return (hi == 32'h0) || (hi == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// rtl/inst_encoder_if.sv - command, encoded-word and status bundle of the instruction encoder
interface inst_encoder_if #(parameter int ICNT_W = 16);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fmt;
    logic [6:0]        in_opcode;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic              err_valid;
    logic [2:0]        err_code;
    logic [ICNT_W-1:0] inst_count;
    logic [7:0]        err_count;

    modport master (
        output in_valid, in_fmt, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
        output out_ready,
        input  in_ready, out_valid, out_inst, err_valid, err_code, inst_count, err_count
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
        input  out_ready,
        output in_ready, out_valid, out_inst, err_valid, err_code, inst_count, err_count
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - power-of-two synchronous FIFO whose read port holds the last popped word when empty
module sync_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_last;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_rdata = o_empty ? r_last : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - range-checks decoded RV32I fields and queues the packed instruction words
module inst_encoder
    import rv_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ICNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    inst_encoder_if.slave bus
);
    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic [31:0]       w_word;
    logic [2:0]        w_err;
    logic [31:0]       w_imm;
    logic              r_err_valid;
    logic [2:0]        r_err_code;
    logic [ICNT_W-1:0] r_inst_count;
    logic [7:0]        r_err_count;

    assign w_imm    = bus.in_imm;
    assign w_accept = bus.in_valid && !w_full;
    assign w_push   = w_accept && (w_err == ERR_NONE);
    assign w_pop    = !w_empty && bus.out_ready;

    always_comb begin
        w_word = {25'd0, bus.in_opcode};
        case (bus.in_fmt)
            FMT_R:   w_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
            FMT_I:   w_word = {w_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
            FMT_ISH: w_word = {bus.in_funct7, w_imm[4:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
            FMT_S:   w_word = {w_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, w_imm[4:0], bus.in_opcode};
            FMT_B:   w_word = {w_imm[12], w_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                               w_imm[4:1], w_imm[11], bus.in_opcode};
            FMT_U:   w_word = {w_imm[31:12], bus.in_rd, bus.in_opcode};
            FMT_J:   w_word = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], bus.in_rd, bus.in_opcode};
            default: w_word = {25'd0, bus.in_opcode};
        endcase
    end

    // Checks are ordered: the first matching rule decides the reported code.
    always_comb begin
        w_err = ERR_NONE;
        if (bus.in_fmt == FMT_RSV) begin
            w_err = ERR_BAD_FMT;
        end else if (bus.in_fmt == FMT_U && w_imm[11:0] != 12'd0) begin
            w_err = ERR_U_LOW;
        end else if ((bus.in_fmt == FMT_B || bus.in_fmt == FMT_J) && w_imm[0]) begin
            w_err = ERR_MISALIGN;
        end else if (((bus.in_fmt == FMT_I || bus.in_fmt == FMT_S) && !fits_signed(w_imm, 12)) ||
                     (bus.in_fmt == FMT_ISH && w_imm[31:5] != 27'd0) ||
                     (bus.in_fmt == FMT_B && !fits_signed(w_imm, 13)) ||
                     (bus.in_fmt == FMT_J && !fits_signed(w_imm, 21))) begin
            w_err = ERR_RANGE;
        end
    end

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_word),
        .i_pop   (w_pop),
        .o_rdata (bus.out_inst),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_valid  <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_inst_count <= '0;
            r_err_count  <= 8'd0;
        end else begin
            r_err_valid <= w_accept && (w_err != ERR_NONE);
            if (w_accept && (w_err != ERR_NONE)) begin
                r_err_code <= w_err;
                if (r_err_count != 8'hFF) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end
            if (w_push) begin
                r_inst_count <= r_inst_count + ICNT_W'(1);
            end
        end
    end

    assign bus.in_ready   = !w_full;
    assign bus.out_valid  = !w_empty;
    assign bus.err_valid  = r_err_valid;
    assign bus.err_code   = r_err_code;
    assign bus.inst_count = r_inst_count;
    assign bus.err_count  = r_err_count;
endmodule
